// File: rtl/d5m_capture_pkg.sv
// Shared types for the D5M pixel-capture path: FSM state encoding and the
// FIFO entry layout carried from the hold register to the output stream.
package d5m_capture_pkg;

    localparam int D5M_DATA_WIDTH = 12;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        IN_FRAME
    } cap_state_e;

    typedef struct packed {
        logic [D5M_DATA_WIDTH-1:0] data;
        logic                      sop;
        logic                      eop;
    } fifo_entry_t;

endpackage

// File: rtl/d5m_capture_if.sv
// Packetised pixel stream toward the frame writer; the capture block is the
// master, the downstream consumer drives out_ready as the slave.
interface d5m_capture_if
    import d5m_capture_pkg::*;
#(
    parameter int DATA_WIDTH = D5M_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_sop;
    logic                  out_eop;

    modport master (output out_data, out_valid, out_sop, out_eop, input out_ready);
    modport slave  (input out_data, out_valid, out_sop, out_eop, output out_ready);
endinterface

// File: rtl/d5m_pixel_fifo.sv
// Show-ahead FIFO: storage array plus a registered head stage. fill_o counts
// every entry held, including the one presented on the head registers.
module d5m_pixel_fifo #(
    parameter  int WIDTH = 14,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_ready_i,
    output logic [WIDTH-1:0] head_data_o,
    output logic             head_valid_o,
    output logic [AW:0]      fill_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      mem_count_q;
    logic [WIDTH-1:0] head_data_q;
    logic             head_valid_q;
    logic             pop;
    logic             load_head;
    logic             wr_en;

    assign pop       = head_valid_q & pop_ready_i;
    assign load_head = (mem_count_q != '0) && (!head_valid_q || pop);
    assign fill_o    = mem_count_q + {{AW{1'b0}}, head_valid_q};
    // A full FIFO still takes a push in the cycle its head is consumed.
    assign wr_en     = push_i && ((fill_o < (AW+1)'(DEPTH)) || pop);

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_data_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            mem_count_q  <= '0;
            head_data_q  <= '0;
            head_valid_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (load_head) rd_ptr_q <= rd_ptr_q + 1'b1;
            mem_count_q <= mem_count_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, load_head};
            if (load_head) begin
                head_data_q  <= mem_q[rd_ptr_q];
                head_valid_q <= 1'b1;
            end else if (pop) begin
                head_valid_q <= 1'b0;
            end
        end
    end

    assign head_data_o  = head_data_q;
    assign head_valid_o = head_valid_q;
endmodule

// File: rtl/d5m_capture.sv
// TRDB-D5M capture front end: registers the raw sensor bus, frames pixels
// into an SOP/EOP stream through a one-pixel hold stage, and buffers it.
//   state    | meaning
//   IDLE     | capture off, or waiting for FVAL low before arming
//   ARMED    | waiting for the next FVAL rising edge
//   IN_FRAME | frame active, pixels flow through the hold register
module d5m_capture
    import d5m_capture_pkg::*;
#(
    parameter int DATA_WIDTH = D5M_DATA_WIDTH,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable_i,
    input  logic                  clear_status_i,
    input  logic                  sensor_frame_valid_i,
    input  logic                  sensor_line_valid_i,
    input  logic [DATA_WIDTH-1:0] sensor_data_i,
    d5m_capture_if.master         stream,
    output logic                  overflow_o,
    output logic [15:0]           frame_count_o,
    output logic [15:0]           last_line_count_o,
    output logic [15:0]           last_line_width_o,
    output logic                  busy_o
);
    localparam int FILL_W = $clog2(FIFO_DEPTH) + 1;

    logic                  s_fval_q, s_lval_q, s_fval_prev_q, s_lval_prev_q;
    logic [DATA_WIDTH-1:0] s_data_q;
    cap_state_e            state_q;
    logic [DATA_WIDTH-1:0] hold_data_q;
    logic                  hold_sop_q, hold_valid_q;
    logic [15:0]           line_cnt_q, line_cnt_d, width_q, width_d;
    logic                  overflow_q, busy_q;
    logic [15:0]           frame_count_q, last_line_count_q, last_line_width_q;

    logic              s_pix, fval_rise, lval_rise, active, room, fall;
    logic              pix_ok, drop, push_eop, push;
    logic [FILL_W-1:0] fifo_fill;
    fifo_entry_t       push_entry, head_entry;

    // Sensor sampling is left out of reset so IDLE sees the true FVAL level
    // right after reset and never arms in the middle of a frame.
    always_ff @(posedge clk) begin
        s_fval_q      <= sensor_frame_valid_i;
        s_lval_q      <= sensor_line_valid_i;
        s_data_q      <= sensor_data_i;
        s_fval_prev_q <= s_fval_q;
        s_lval_prev_q <= s_lval_q;
    end

    assign s_pix     = s_fval_q & s_lval_q;
    assign fval_rise = s_fval_q & ~s_fval_prev_q;
    assign lval_rise = s_lval_q & ~s_lval_prev_q & s_fval_q;
    assign active    = (state_q == IN_FRAME) || (state_q == ARMED && enable_i && fval_rise);
    assign fall      = (state_q == IN_FRAME) && !s_fval_q;
    // The last slot stays free so an accepted frame can always close with EOP.
    assign room      = fifo_fill < FILL_W'(FIFO_DEPTH - 1);
    assign pix_ok    = active && s_pix && room;
    assign drop      = active && s_pix && !room;
    assign push_eop  = fall && hold_valid_q;
    assign push      = (pix_ok && hold_valid_q) || push_eop;

    assign push_entry.data = hold_data_q;
    assign push_entry.sop  = hold_sop_q;
    assign push_entry.eop  = push_eop;

    always_comb begin
        line_cnt_d = line_cnt_q;
        width_d    = width_q;
        if (state_q == ARMED) begin
            line_cnt_d = '0;
            width_d    = '0;
        end
        if (active) begin
            if (lval_rise) begin
                line_cnt_d = line_cnt_d + 16'd1;
                width_d    = '0;
            end
            if (s_pix && width_d != 16'hFFFF) width_d = width_d + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= IDLE;
            busy_q            <= 1'b0;
            hold_data_q       <= '0;
            hold_sop_q        <= 1'b0;
            hold_valid_q      <= 1'b0;
            line_cnt_q        <= '0;
            width_q           <= '0;
            overflow_q        <= 1'b0;
            frame_count_q     <= '0;
            last_line_count_q <= '0;
            last_line_width_q <= '0;
        end else begin
            line_cnt_q <= line_cnt_d;
            width_q    <= width_d;
            case (state_q)
                IDLE: begin
                    if (enable_i && !s_fval_q) begin
                        state_q <= ARMED;
                        busy_q  <= 1'b1;
                    end
                end
                ARMED: begin
                    if (!enable_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (fval_rise) begin
                        state_q <= IN_FRAME;
                    end
                end
                IN_FRAME: begin
                    if (fall) begin
                        state_q <= enable_i ? ARMED : IDLE;
                        busy_q  <= enable_i;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
            // A pixel landing in an empty hold register opens the packet.
            if (pix_ok) begin
                hold_data_q  <= s_data_q;
                hold_sop_q   <= !hold_valid_q;
                hold_valid_q <= 1'b1;
            end else if (fall) begin
                hold_valid_q <= 1'b0;
            end
            if (push_eop) begin
                frame_count_q     <= frame_count_q + 16'd1;
                last_line_count_q <= line_cnt_q;
                last_line_width_q <= width_q;
            end
            if (drop) overflow_q <= 1'b1;
            else if (clear_status_i) overflow_q <= 1'b0;
        end
    end

    d5m_pixel_fifo #(
        .WIDTH($bits(fifo_entry_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_ready_i (stream.out_ready),
        .head_data_o (head_entry),
        .head_valid_o(stream.out_valid),
        .fill_o      (fifo_fill)
    );

    assign stream.out_data   = head_entry.data;
    assign stream.out_sop    = head_entry.sop;
    assign stream.out_eop    = head_entry.eop;
    assign overflow_o        = overflow_q;
    assign frame_count_o     = frame_count_q;
    assign last_line_count_o = last_line_count_q;
    assign last_line_width_o = last_line_width_q;
    assign busy_o            = busy_q;
endmodule

// File: tb/tb_d5m_capture.sv
// Scoreboard bench for d5m_capture: sensor frames are generated by tasks that
// queue the expected beats; a negedge monitor pops and compares each beat.
module tb_d5m_capture;
    import d5m_capture_pkg::*;

    localparam int DW = 12;

    typedef struct {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          clear_status = 1'b0;
    logic          fval = 1'b0;
    logic          lval = 1'b0;
    logic [DW-1:0] sdata = '0;
    logic          overflow, busy;
    logic [15:0]   frame_count, last_line_count, last_line_width;

    int    checks = 0;
    int    errors = 0;
    int    exp_fc = 0;
    int    ready_mode = 1;
    logic  rnd_bit = 1'b1;
    beat_t exp_q[$];
    beat_t mon_e;
    logic  prev_stall = 1'b0;
    logic [DW+1:0] prev_beat = '0;

    d5m_capture_if #(.DATA_WIDTH(DW)) stream_if ();

    d5m_capture #(.DATA_WIDTH(DW), .FIFO_DEPTH(16)) dut (
        .clk                 (clk),
        .reset               (reset),
        .enable_i            (enable),
        .clear_status_i      (clear_status),
        .sensor_frame_valid_i(fval),
        .sensor_line_valid_i (lval),
        .sensor_data_i       (sdata),
        .stream              (stream_if),
        .overflow_o          (overflow),
        .frame_count_o       (frame_count),
        .last_line_count_o   (last_line_count),
        .last_line_width_o   (last_line_width),
        .busy_o              (busy)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #2;
        rnd_bit = ($urandom_range(0, 3) != 0);
    end

    assign stream_if.out_ready = (ready_mode == 2) ? rnd_bit : (ready_mode == 1);

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if ({stream_if.out_valid, stream_if.out_data, stream_if.out_sop, stream_if.out_eop}
                    !== {1'b1, prev_beat}) begin
                    errors++;
                    $display("FAIL stall_hold got valid=%b data=%h sop=%b eop=%b required held %h",
                             stream_if.out_valid, stream_if.out_data, stream_if.out_sop,
                             stream_if.out_eop, prev_beat);
                end
            end
            if (stream_if.out_valid && stream_if.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat got data=%h sop=%b eop=%b required no beat",
                             stream_if.out_data, stream_if.out_sop, stream_if.out_eop);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({stream_if.out_data, stream_if.out_sop, stream_if.out_eop}
                        !== {mon_e.data, mon_e.sop, mon_e.eop}) begin
                        errors++;
                        $display("FAIL beat got data=%h sop=%b eop=%b required data=%h sop=%b eop=%b",
                                 stream_if.out_data, stream_if.out_sop, stream_if.out_eop,
                                 mon_e.data, mon_e.sop, mon_e.eop);
                    end
                end
            end
            prev_stall = stream_if.out_valid && !stream_if.out_ready;
            prev_beat  = {stream_if.out_data, stream_if.out_sop, stream_if.out_eop};
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Queues the first n_exp pixels as expected beats; the last queued one closes the packet.
    task automatic send_frame(input int lines, input int ppl, input int base, input int n_exp,
                              input int ctl_line, input logic ctl_en);
        int    idx;
        int    last;
        beat_t b;
        idx  = 0;
        last = ((n_exp < lines * ppl) ? n_exp : lines * ppl) - 1;
        fval = 1'b1;
        lval = 1'b0;
        tick(2);
        for (int l = 0; l < lines; l++) begin
            if (l == ctl_line) enable = ctl_en;
            for (int p = 0; p < ppl; p++) begin
                lval  = 1'b1;
                sdata = DW'(base + idx);
                if (idx <= last) begin
                    b.data = DW'(base + idx);
                    b.sop  = (idx == 0);
                    b.eop  = (idx == last);
                    exp_q.push_back(b);
                end
                idx++;
                tick(1);
            end
            lval  = 1'b0;
            sdata = '0;
            tick(3);
        end
        fval = 1'b0;
        tick(4);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            tick(1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got %0d beats outstanding required 0", name, exp_q.size());
            exp_q.delete();
        end
        tick(5);
    endtask

    task automatic check_status(input string name, input int fc, input int llc, input int llw);
        checks++;
        if (frame_count !== 16'(fc)) begin
            errors++;
            $display("FAIL %s_frame_count got %0d required %0d", name, frame_count, fc);
        end
        checks++;
        if (last_line_count !== 16'(llc)) begin
            errors++;
            $display("FAIL %s_line_count got %0d required %0d", name, last_line_count, llc);
        end
        checks++;
        if (last_line_width !== 16'(llw)) begin
            errors++;
            $display("FAIL %s_line_width got %0d required %0d", name, last_line_width, llw);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        checks++;
        if ({stream_if.out_valid, stream_if.out_sop, stream_if.out_eop} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got valid/sop/eop=%b%b%b required 000",
                     stream_if.out_valid, stream_if.out_sop, stream_if.out_eop);
        end
        checks++;
        if (stream_if.out_data !== '0) begin
            errors++;
            $display("FAIL reset_data got %h required 000", stream_if.out_data);
        end
        checks++;
        if ({overflow, busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_overflow_busy got %b%b required 00", overflow, busy);
        end
        check_status("reset", 0, 0, 0);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_latency();
        beat_t b;
        enable     = 1'b1;
        ready_mode = 1;
        tick(3);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL armed_busy got %b required 1", busy);
        end
        for (int i = 0; i < 4; i++) begin
            b.data = DW'(12'h0A0 + i);
            b.sop  = (i == 0);
            b.eop  = (i == 3);
            exp_q.push_back(b);
        end
        fval = 1'b1;
        tick(2);
        lval  = 1'b1;
        sdata = 12'h0A0;
        tick(1);
        sdata = 12'h0A1;
        tick(1);
        sdata = 12'h0A2;
        tick(1);
        checks++;
        if (stream_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early got valid=%b required 0 at k+2", stream_if.out_valid);
        end
        sdata = 12'h0A3;
        tick(1);
        checks++;
        if ({stream_if.out_valid, stream_if.out_data, stream_if.out_sop} !== {1'b1, 12'h0A0, 1'b1}) begin
            errors++;
            $display("FAIL latency_k3 got valid=%b data=%h sop=%b required 1 0a0 1",
                     stream_if.out_valid, stream_if.out_data, stream_if.out_sop);
        end
        lval = 1'b0;
        tick(3);
        fval = 1'b0;
        tick(4);
        wait_drain("latency");
        exp_fc++;
        check_status("latency", exp_fc, 1, 4);
    endtask

    task automatic test_basic_frame();
        send_frame(4, 8, 12'h100, 32, -1, 1'b1);
        wait_drain("basic");
        exp_fc++;
        check_status("basic", exp_fc, 4, 8);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL basic_overflow got %b required 0", overflow);
        end
    endtask

    task automatic test_edge_frames();
        send_frame(1, 1, 12'h3C5, 1, -1, 1'b1);
        wait_drain("one_pixel");
        exp_fc++;
        check_status("one_pixel", exp_fc, 1, 1);
        send_frame(0, 0, 0, 0, -1, 1'b1);
        tick(10);
        check_status("empty_frame", exp_fc, 1, 1);
    endtask

    task automatic test_mid_frame_start();
        enable = 1'b0;
        tick(3);
        send_frame(3, 4, 12'h600, 0, 1, 1'b1);
        send_frame(2, 4, 12'h700, 8, -1, 1'b1);
        wait_drain("mid_start");
        exp_fc++;
        check_status("mid_start", exp_fc, 2, 4);
    endtask

    task automatic test_backpressure();
        ready_mode = 0;
        send_frame(1, 40, 12'h200, 16, -1, 1'b1);
        checks++;
        if ({overflow, stream_if.out_valid} !== 2'b11) begin
            errors++;
            $display("FAIL bp_overflow got overflow=%b valid=%b required 1 1",
                     overflow, stream_if.out_valid);
        end
        ready_mode = 1;
        wait_drain("backpressure");
        exp_fc++;
        check_status("backpressure", exp_fc, 1, 40);
        clear_status = 1'b1;
        tick(1);
        clear_status = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL bp_clear got %b required 0", overflow);
        end
    endtask

    task automatic test_back_to_back();
        ready_mode = 2;
        send_frame(3, 4, 12'h800, 12, -1, 1'b1);
        send_frame(2, 3, 12'h900, 6, -1, 1'b1);
        wait_drain("back_to_back");
        ready_mode = 1;
        exp_fc += 2;
        check_status("back_to_back", exp_fc, 2, 3);
    endtask

    task automatic test_enable_drop();
        enable = 1'b1;
        tick(2);
        send_frame(3, 6, 12'h500, 18, 1, 1'b0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL drop_busy got %b required 0", busy);
        end
        wait_drain("enable_drop");
        exp_fc++;
        check_status("enable_drop", exp_fc, 3, 6);
        send_frame(2, 4, 12'h580, 0, -1, 1'b0);
        tick(10);
        check_status("disabled_frame", exp_fc, 3, 6);
        enable = 1'b1;
        tick(2);
    endtask

    task automatic test_reset_mid_frame();
        ready_mode = 0;
        fval = 1'b1;
        tick(2);
        lval = 1'b1;
        for (int p = 0; p < 10; p++) begin
            sdata = DW'(12'h480 + p);
            tick(1);
        end
        reset = 1'b1;
        tick(1);
        checks++;
        if ({stream_if.out_valid, busy, overflow} !== 3'b000) begin
            errors++;
            $display("FAIL rst_mid_flags got valid/busy/ovf=%b%b%b required 000",
                     stream_if.out_valid, busy, overflow);
        end
        check_status("rst_mid", 0, 0, 0);
        reset = 1'b0;
        tick(6);
        lval = 1'b0;
        tick(3);
        fval = 1'b0;
        ready_mode = 1;
        tick(10);
        check_status("rst_aborted", 0, 0, 0);
        send_frame(2, 5, 12'h400, 10, -1, 1'b1);
        wait_drain("rst_next");
        check_status("rst_next", 1, 2, 5);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_basic_frame();
        test_edge_frames();
        test_mid_frame_start();
        test_backpressure();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
